vec_load_unit: RTL and testbench

Strided vector load engine that fills one entry of the vector register file. It accepts a load request (destination vector index, base address, stride), issues 16 in-order word reads to data memory, and collects the returned words into lanes 0..15. It then writes the assembled vector through the register file's single write port in one cycle. It sits between the decode/issue stage and the vector register file's write port.

---
 rtl/vec_load_unit.sv | 113 +++++++++++
 tb/tb_vec_load_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_load_unit.sv
// Strided vector load: 16 in-order word reads assembled into one register-file write.
// 18 cycles request-to-write minimum; memory stalls and response delays add cycles one-for-one.
module vec_load_unit #(
    parameter int VEC_SIZE        = 32,
    parameter int VEC_INDEX_WIDTH = 3,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_req_valid,
    output logic                               o_req_ready,
    input  logic [VEC_INDEX_WIDTH-1:0]         i_req_vec,
    input  logic [ADDR_WIDTH-1:0]              i_req_addr,
    input  logic [ADDR_WIDTH-1:0]              i_req_stride,
    output logic                               o_mem_valid,
    input  logic                               i_mem_ready,
    output logic [ADDR_WIDTH-1:0]              o_mem_addr,
    input  logic                               i_mem_rvalid,
    input  logic [VEC_SIZE-1:0]                i_mem_rdata,
    output logic                               o_vec_we,
    output logic [VEC_INDEX_WIDTH-1:0]         o_vec_waddr,
    output logic [15:0][VEC_SIZE-1:0]          o_vec_wdata,
    output logic                               o_busy,
    output logic                               o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [4:0]                   r_issue_cnt;
    logic [4:0]                   r_resp_cnt;
    logic [ADDR_WIDTH-1:0]        r_addr;
    logic [ADDR_WIDTH-1:0]        r_stride;
    logic [VEC_INDEX_WIDTH-1:0]   r_vec;
    logic [15:0][VEC_SIZE-1:0]    r_lanes;
    logic                         w_accept;
    logic                         w_issue;
    logic                         w_resp;

    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 1'b0;
        o_mem_valid = 1'b0;
        o_vec_we    = 1'b0;
        o_done      = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_req_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_mem_valid = ~r_issue_cnt[4];
                if (i_mem_rvalid && (r_resp_cnt == 5'd15)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                o_vec_we    = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = i_req_valid & o_req_ready;
    assign w_issue  = o_mem_valid & i_mem_ready;
    // Responses outside RUN are stray (e.g. in flight across a reset) and dropped.
    assign w_resp   = (r_state == S_RUN) & i_mem_rvalid & ~r_resp_cnt[4];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= 5'd0;
            r_resp_cnt  <= 5'd0;
            r_addr      <= '0;
            r_stride    <= '0;
            r_vec       <= '0;
            r_lanes     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_vec       <= i_req_vec;
                r_stride    <= i_req_stride;
                r_addr      <= i_req_addr;
                r_issue_cnt <= 5'd0;
                r_resp_cnt  <= 5'd0;
            end
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 5'd1;
                r_addr      <= r_addr + r_stride;
            end
            if (w_resp) begin
                r_lanes[r_resp_cnt[3:0]] <= i_mem_rdata;
                r_resp_cnt               <= r_resp_cnt + 5'd1;
            end
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_vec_waddr = r_vec;
    assign o_vec_wdata = r_lanes;

endmodule

// File: tb/tb_vec_load_unit.sv
module tb_vec_load_unit;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_req_valid = 1'b0;
    logic              o_req_ready;
    logic [2:0]        i_req_vec = '0;
    logic [31:0]       i_req_addr = '0;
    logic [31:0]       i_req_stride = '0;
    logic              o_mem_valid;
    logic              i_mem_ready = 1'b0;
    logic [31:0]       o_mem_addr;
    logic              i_mem_rvalid = 1'b0;
    logic [31:0]       i_mem_rdata = '0;
    logic              o_vec_we;
    logic [2:0]        o_vec_waddr;
    logic [15:0][31:0] o_vec_wdata;
    logic              o_busy;
    logic              o_done;

    vec_load_unit #(.VEC_SIZE(32), .VEC_INDEX_WIDTH(3), .ADDR_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_vec(i_req_vec), .i_req_addr(i_req_addr), .i_req_stride(i_req_stride),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_vec_we(o_vec_we), .o_vec_waddr(o_vec_waddr), .o_vec_wdata(o_vec_wdata),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0, acc_cyc = 0, we_cyc = 0, we_cnt = 0;
    int resp_seen = 0, iss_n = 0, hold_err = 0, done_err = 0, stall_n = 0;
    bit bp_mode = 0, var_lat = 0, noise_en = 0;
    pend_t       pend_q[$];
    logic [31:0] iss_q[$];
    int          acc_q[$];
    logic [2:0]        cap_waddr;
    logic [15:0][31:0] cap_wdata;

    // Memory model (mem[a] = a, in-order responses) plus activity log, once per cycle.
    initial begin
        bit          prev_stall;
        logic [31:0] prev_addr;
        pend_t       p;
        int          lat;
        prev_stall = 0;
        prev_addr  = '0;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (i_rst) begin
                pend_q.delete();
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = '0;
                prev_stall   = 0;
            end else begin
                if (i_req_valid && o_req_ready) begin
                    acc_cyc = cyc;
                    acc_q.push_back(cyc);
                end
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = '0;
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    p = pend_q.pop_front();
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = p.addr;
                    resp_seen++;
                end else if (noise_en && !o_busy) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = 32'hDEADBEEF;
                end
                i_mem_ready = bp_mode ? (((cyc - acc_cyc) % 2) == 0) : 1'b1;
                if (prev_stall && o_mem_valid && (o_mem_addr !== prev_addr)) hold_err++;
                prev_stall = o_mem_valid && !i_mem_ready;
                if (prev_stall) stall_n++;
                prev_addr = o_mem_addr;
                if (o_mem_valid && i_mem_ready) begin
                    lat = var_lat ? (1 + ((iss_n * 3) % 4)) : 1;
                    pend_q.push_back('{o_mem_addr, cyc + lat});
                    iss_q.push_back(o_mem_addr);
                    iss_n++;
                end
            end
            if (o_vec_we) begin
                we_cnt++;
                we_cyc    = cyc;
                cap_waddr = o_vec_waddr;
                cap_wdata = o_vec_wdata;
            end
            if (o_done !== o_vec_we) done_err++;
        end
    end

    task automatic clear_log();
        iss_q.delete();
        iss_n     = 0;
        resp_seen = 0;
    endtask

    task automatic do_req(input logic [2:0] vec, input logic [31:0] addr, input logic [31:0] stride);
        bit ok;
        ok = 0;
        @(posedge i_clk); #1;
        i_req_vec    = vec;
        i_req_addr   = addr;
        i_req_stride = stride;
        i_req_valid  = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge i_clk);
            if (o_req_ready) ok = 1;
        end
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL req_accept: o_req_ready never seen within 200 cycles");
        end
    endtask

    task automatic wait_done(input int n0, input int budget, input string tag);
        int i;
        i = 0;
        while (we_cnt == n0 && i < budget) begin
            @(negedge i_clk); #1;
            i++;
        end
        if (we_cnt == n0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no o_vec_we within %0d cycles", tag, budget);
        end
    endtask

    task automatic test_reset();
        @(negedge i_clk); #1;
        checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        checks++; if (o_mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid: got %b want 0", o_mem_valid); end
        checks++; if (o_vec_we !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL rst_we_done: got %b%b want 00", o_vec_we, o_done); end
        checks++; if (o_mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", o_mem_addr); end
        checks++; if (o_vec_waddr !== 3'd0 || o_vec_wdata !== '0) begin errors++; $display("FAIL rst_wbuf: got waddr %0d lane0 %h want 0", o_vec_waddr, o_vec_wdata[0]); end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk); #1;
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", o_req_ready); end
    endtask

    task automatic test_unit_stride();
        int n0;
        logic [31:0] e;
        clear_log();
        n0 = we_cnt;
        do_req(3'd5, 32'h100, 32'd4);
        wait_done(n0, 100, "unit");
        checks++; if (we_cyc - acc_cyc != 18) begin errors++; $display("FAIL unit_latency: got %0d want 18", we_cyc - acc_cyc); end
        checks++; if (cap_waddr !== 3'd5) begin errors++; $display("FAIL unit_waddr: got %0d want 5", cap_waddr); end
        checks++; if (iss_q.size() != 16) begin errors++; $display("FAIL unit_issue_cnt: got %0d want 16", iss_q.size()); end
        for (int k = 0; k < 16; k++) begin
            e = 32'h100 + 32'(k) * 32'd4;
            checks++;
            if (k >= iss_q.size() || iss_q[k] !== e) begin errors++; $display("FAIL unit_addr[%0d]: want %h", k, e); end
            checks++;
            if (cap_wdata[k] !== e) begin errors++; $display("FAIL unit_lane[%0d]: got %h want %h", k, cap_wdata[k], e); end
        end
        @(negedge i_clk); #1;
        checks++; if (o_req_ready !== 1'b1 || o_vec_we !== 1'b0) begin errors++; $display("FAIL unit_after: ready %b we %b want 1 0", o_req_ready, o_vec_we); end
        checks++; if (o_vec_wdata[15] !== 32'h13C) begin errors++; $display("FAIL unit_hold_lane15: got %h want 0000013c", o_vec_wdata[15]); end
        checks++; if (we_cnt - n0 != 1) begin errors++; $display("FAIL unit_we_count: got %0d want 1", we_cnt - n0); end
    endtask

    task automatic test_backpressure();
        int n0, s0;
        logic [31:0] e;
        clear_log();
        bp_mode = 1;
        s0 = stall_n;
        hold_err = 0;
        n0 = we_cnt;
        do_req(3'd2, 32'h100, 32'd4);
        wait_done(n0, 150, "bp");
        bp_mode = 0;
        checks++; if (we_cyc - acc_cyc != 34) begin errors++; $display("FAIL bp_latency: got %0d want 34", we_cyc - acc_cyc); end
        checks++; if (hold_err != 0 || stall_n == s0) begin errors++; $display("FAIL bp_addr_hold: %0d changes over %0d stalls, want 0 changes", hold_err, stall_n - s0); end
        checks++; if (iss_q.size() != 16) begin errors++; $display("FAIL bp_issue_cnt: got %0d want 16", iss_q.size()); end
        checks++; if (cap_waddr !== 3'd2) begin errors++; $display("FAIL bp_waddr: got %0d want 2", cap_waddr); end
        for (int k = 0; k < 16; k++) begin
            e = 32'h100 + 32'(k) * 32'd4;
            checks++;
            if (cap_wdata[k] !== e) begin errors++; $display("FAIL bp_lane[%0d]: got %h want %h", k, cap_wdata[k], e); end
        end
    endtask

    task automatic test_wrap();
        int n0;
        logic [31:0] e;
        clear_log();
        n0 = we_cnt;
        do_req(3'd3, 32'hFFFF_FFF8, 32'd4);
        wait_done(n0, 100, "wrap");
        checks++; if (we_cyc - acc_cyc != 18) begin errors++; $display("FAIL wrap_latency: got %0d want 18", we_cyc - acc_cyc); end
        checks++; if (cap_wdata[2] !== 32'h0 || cap_wdata[15] !== 32'h34) begin errors++; $display("FAIL wrap_edges: lane2 %h lane15 %h want 0 34", cap_wdata[2], cap_wdata[15]); end
        for (int k = 0; k < 16; k++) begin
            e = 32'hFFFF_FFF8 + 32'(k) * 32'd4;
            checks++;
            if (k >= iss_q.size() || iss_q[k] !== e || cap_wdata[k] !== e) begin errors++; $display("FAIL wrap_lane[%0d]: got %h want %h", k, cap_wdata[k], e); end
        end
    endtask

    task automatic test_var_latency();
        int n0;
        logic [31:0] e;
        clear_log();
        var_lat = 1;
        n0 = we_cnt;
        do_req(3'd4, 32'h1000, 32'h20);
        wait_done(n0, 100, "varlat");
        repeat (3) @(negedge i_clk);
        #1;
        var_lat = 0;
        checks++; if (we_cyc - acc_cyc != 21) begin errors++; $display("FAIL varlat_latency: got %0d want 21", we_cyc - acc_cyc); end
        checks++; if (we_cnt - n0 != 1) begin errors++; $display("FAIL varlat_we_count: got %0d want 1", we_cnt - n0); end
        checks++; if (cap_waddr !== 3'd4) begin errors++; $display("FAIL varlat_waddr: got %0d want 4", cap_waddr); end
        for (int k = 0; k < 16; k++) begin
            e = 32'h1000 + 32'(k) * 32'h20;
            checks++;
            if (cap_wdata[k] !== e) begin errors++; $display("FAIL varlat_lane[%0d]: got %h want %h", k, cap_wdata[k], e); end
        end
    endtask

    task automatic test_reset_midload();
        int n0, i;
        logic [31:0] e;
        clear_log();
        n0 = we_cnt;
        do_req(3'd2, 32'h2000, 32'd8);
        i = 0;
        while (resp_seen < 7 && i < 100) begin @(negedge i_clk); #1; i++; end
        checks++; if (resp_seen < 7) begin errors++; $display("FAIL midrst_resp: got %0d responses want 7", resp_seen); end
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(negedge i_clk); #1;
        checks++; if (o_busy !== 1'b0 || o_mem_valid !== 1'b0) begin errors++; $display("FAIL midrst_busy: busy %b mem_valid %b want 0 0", o_busy, o_mem_valid); end
        checks++; if (o_mem_addr !== 32'h0) begin errors++; $display("FAIL midrst_mem_addr: got %h want 0", o_mem_addr); end
        checks++; if (o_vec_wdata !== '0 || o_vec_waddr !== 3'd0) begin errors++; $display("FAIL midrst_wbuf: lane0 %h waddr %0d want 0", o_vec_wdata[0], o_vec_waddr); end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
        #1;
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", o_req_ready); end
        checks++; if (we_cnt != n0) begin errors++; $display("FAIL midrst_no_write: got %0d writes want 0", we_cnt - n0); end
        clear_log();
        n0 = we_cnt;
        do_req(3'd6, 32'h40, 32'h10);
        wait_done(n0, 100, "midrst_fresh");
        checks++; if (we_cyc - acc_cyc != 18 || cap_waddr !== 3'd6) begin errors++; $display("FAIL midrst_fresh: latency %0d waddr %0d want 18 6", we_cyc - acc_cyc, cap_waddr); end
        for (int k = 0; k < 16; k++) begin
            e = 32'h40 + 32'(k) * 32'h10;
            checks++;
            if (cap_wdata[k] !== e) begin errors++; $display("FAIL midrst_lane[%0d]: got %h want %h", k, cap_wdata[k], e); end
        end
    endtask

    task automatic test_busy_request();
        int n0, na, wa, i;
        logic [31:0] e;
        noise_en = 1;
        repeat (5) @(negedge i_clk);
        #1;
        checks++; if (o_vec_wdata[0] !== 32'h40 || o_busy !== 1'b0) begin errors++; $display("FAIL noise_idle: lane0 %h busy %b want 00000040 0", o_vec_wdata[0], o_busy); end
        clear_log();
        n0 = we_cnt;
        do_req(3'd1, 32'h500, 32'hC);
        i_req_vec    = 3'd7;
        i_req_addr   = 32'h800;
        i_req_stride = 32'hFFFF_FFFC;
        i_req_valid  = 1'b1;
        na = acc_q.size();
        @(negedge i_clk); #1;
        checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", o_req_ready); end
        wait_done(n0, 100, "busyA");
        wa = we_cyc;
        checks++; if (cap_waddr !== 3'd1) begin errors++; $display("FAIL busyA_waddr: got %0d want 1", cap_waddr); end
        for (int k = 0; k < 16; k++) begin
            e = 32'h500 + 32'(k) * 32'hC;
            checks++;
            if (cap_wdata[k] !== e) begin errors++; $display("FAIL busyA_lane[%0d]: got %h want %h", k, cap_wdata[k], e); end
        end
        i = 0;
        while (acc_q.size() == na && i < 50) begin @(negedge i_clk); #1; i++; end
        checks++;
        if (acc_q.size() != na + 1 || acc_q[acc_q.size()-1] != wa + 1) begin
            errors++; $display("FAIL busyB_accept: %0d accepts, last at cycle %0d, want 1 at cycle %0d", acc_q.size() - na, acc_q.size() > 0 ? acc_q[acc_q.size()-1] : -1, wa + 1);
        end
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        clear_log();
        n0 = we_cnt;
        wait_done(n0, 100, "busyB");
        noise_en = 0;
        checks++; if (we_cyc - acc_cyc != 18 || cap_waddr !== 3'd7) begin errors++; $display("FAIL busyB_write: latency %0d waddr %0d want 18 7", we_cyc - acc_cyc, cap_waddr); end
        for (int k = 0; k < 16; k++) begin
            e = 32'h800 - 32'(k) * 32'd4;
            checks++;
            if (cap_wdata[k] !== e) begin errors++; $display("FAIL busyB_lane[%0d]: got %h want %h", k, cap_wdata[k], e); end
        end
    endtask

    initial begin
        test_reset();
        test_unit_stride();
        test_backpressure();
        test_wrap();
        test_var_latency();
        test_reset_midload();
        test_busy_request();
        repeat (3) @(negedge i_clk);
        #1;
        checks++; if (done_err != 0) begin errors++; $display("FAIL done_vs_we: %0d cycles where o_done differed from o_vec_we, want 0", done_err); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
